// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - ID/EX hazard, flush and mult/div busy sequencing controller
module hazard_stall_ctrl #(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 16,
    parameter int CNT_W   = 5,
    parameter int PERF_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic              id_uses_hilo,
    input  logic              id_md_start,
    input  logic              id_md_is_div,
    input  logic [4:0]        ex_rd,
    input  logic              ex_memread,
    input  logic              ex_br_taken,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic              md_busy,
    output logic              md_done,
    output logic [PERF_W-1:0] stall_cnt
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [CNT_W-1:0] MUL_INIT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(DIV_LAT - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             load_use;
    logic             md_haz;
    logic             stall;
    logic             issue;

    // Register $0 is hardwired, so a load targeting it never creates a dependency.
    assign load_use = ex_memread && (ex_rd != 5'd0) &&
                      ((id_uses_rs && (id_rs == ex_rd)) || (id_uses_rt && (id_rt == ex_rd)));
    assign md_haz   = (state == BUSY) && (id_uses_hilo || id_md_start);
    assign stall    = (load_use || md_haz) && !ex_br_taken;
    assign issue    = (state == IDLE) && id_md_start && !stall && !ex_br_taken;

    assign md_busy  = (state == BUSY);
    assign md_done  = (state == BUSY) && (cnt == '0);

    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        if (ex_br_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (stall) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            stall_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue) begin
                        state <= BUSY;
                        cnt   <= id_md_is_div ? DIV_INIT : MUL_INIT;
                    end
                end
                BUSY: begin
                    // A taken branch does not abort: the op already left ID.
                    if (cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
            if (!pc_en && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - directed vector bench for hazard_stall_ctrl
module tb_hazard_stall_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [4:0]  id_rs, id_rt, ex_rd;
    logic        id_uses_rs, id_uses_rt, id_uses_hilo, id_md_start, id_md_is_div;
    logic        ex_memread, ex_br_taken;
    logic        pc_en, ifid_en, ifid_flush, idex_bubble, md_busy, md_done;
    logic [15:0] stall_cnt;
    logic        pc_en4, ifid_en4, ifid_flush4, idex_bubble4, md_busy4, md_done4;
    logic [3:0]  stall_cnt4;

    hazard_stall_ctrl u_dut (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_uses_hilo(id_uses_hilo),
        .id_md_start(id_md_start), .id_md_is_div(id_md_is_div), .ex_rd(ex_rd),
        .ex_memread(ex_memread), .ex_br_taken(ex_br_taken), .pc_en(pc_en),
        .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
        .md_busy(md_busy), .md_done(md_done), .stall_cnt(stall_cnt)
    );

    hazard_stall_ctrl #(.PERF_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_uses_hilo(id_uses_hilo),
        .id_md_start(id_md_start), .id_md_is_div(id_md_is_div), .ex_rd(ex_rd),
        .ex_memread(ex_memread), .ex_br_taken(ex_br_taken), .pc_en(pc_en4),
        .ifid_en(ifid_en4), .ifid_flush(ifid_flush4), .idex_bubble(idex_bubble4),
        .md_busy(md_busy4), .md_done(md_done4), .stall_cnt(stall_cnt4)
    );

    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rs;
        logic       uses_rt;
        logic [4:0] rd;
        logic       memread;
        logic       br;
        logic       md_start;
        logic       e_pc_en;
        logic       e_ifid_en;
        logic       e_flush;
        logic       e_bubble;
    } vec_t;

    vec_t vecs[10];
    int   total = 0;
    int   bad   = 0;
    int   exp_sc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic clear_in();
        id_rs = 0; id_rt = 0; ex_rd = 0;
        id_uses_rs = 0; id_uses_rt = 0; id_uses_hilo = 0;
        id_md_start = 0; id_md_is_div = 0; ex_memread = 0; ex_br_taken = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int busy_n, done_n, stall_n;
        //                rs  rt  urs urt rd  mr br md   pc id fl bb
        vecs[0] = '{5'd5, 5'd0, 1, 0, 5'd5, 1, 0, 0,    0, 0, 0, 1}; // load-use rs
        vecs[1] = '{5'd5, 5'd0, 1, 0, 5'd5, 0, 0, 0,    1, 1, 0, 0}; // load gone
        vecs[2] = '{5'd0, 5'd7, 0, 1, 5'd7, 1, 0, 0,    0, 0, 0, 1}; // load-use rt
        vecs[3] = '{5'd0, 5'd7, 0, 0, 5'd7, 1, 0, 0,    1, 1, 0, 0}; // rt not read
        vecs[4] = '{5'd0, 5'd0, 1, 1, 5'd0, 1, 0, 0,    1, 1, 0, 0}; // $0 never hazards
        vecs[5] = '{5'd9, 5'd0, 1, 0, 5'd9, 1, 1, 0,    1, 1, 1, 1}; // load-use + branch
        vecs[6] = '{5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0,    1, 1, 1, 1}; // branch alone
        vecs[7] = '{5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 1,    1, 1, 1, 1}; // div squashed by branch
        vecs[8] = '{5'd3, 5'd0, 1, 0, 5'd3, 1, 0, 1,    0, 0, 0, 1}; // stalled mult no issue
        vecs[9] = '{5'd3, 5'd0, 1, 0, 5'd5, 1, 0, 0,    1, 1, 0, 0}; // reg mismatch

        clear_in();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_pc_en", pc_en, 1);
        chk("rst_ifid_en", ifid_en, 1);
        chk("rst_flush", ifid_flush, 0);
        chk("rst_bubble", idex_bubble, 0);
        chk("rst_busy", md_busy, 0);
        chk("rst_done", md_done, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst4_outputs", {pc_en4, ifid_en4, ifid_flush4, idex_bubble4, md_busy4, md_done4}, 6'b110000);
        chk("rst4_stall_cnt", stall_cnt4, 0);

        exp_sc = 0;
        for (int i = 0; i < 10; i++) begin
            clear_in();
            id_rs = vecs[i].rs; id_rt = vecs[i].rt;
            id_uses_rs = vecs[i].uses_rs; id_uses_rt = vecs[i].uses_rt;
            ex_rd = vecs[i].rd; ex_memread = vecs[i].memread;
            ex_br_taken = vecs[i].br; id_md_start = vecs[i].md_start; id_md_is_div = 1'b1;
            #1;
            chk($sformatf("v%0d_pc_en", i), pc_en, vecs[i].e_pc_en);
            chk($sformatf("v%0d_ifid_en", i), ifid_en, vecs[i].e_ifid_en);
            chk($sformatf("v%0d_flush", i), ifid_flush, vecs[i].e_flush);
            chk($sformatf("v%0d_bubble", i), idex_bubble, vecs[i].e_bubble);
            tick();
            if (!vecs[i].e_pc_en) exp_sc++;
            chk($sformatf("v%0d_stall_cnt", i), stall_cnt, exp_sc);
            chk($sformatf("v%0d_busy_after", i), md_busy, 0);
        end

        // mult then dependent mflo
        clear_in();
        id_md_start = 1'b1;
        #1;
        chk("mul_issue_pc_en", pc_en, 1);
        tick();
        clear_in();
        id_uses_hilo = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("mul_c%0d_busy", i), md_busy, 1);
            chk($sformatf("mul_c%0d_pc_en", i), pc_en, 0);
            chk($sformatf("mul_c%0d_bubble", i), idex_bubble, 1);
            chk($sformatf("mul_c%0d_done", i), md_done, (i == 3));
            tick();
            exp_sc++;
        end
        #1;
        chk("mul_after_busy", md_busy, 0);
        chk("mul_after_pc_en", pc_en, 1);
        chk("mul_after_done", md_done, 0);
        chk("mul_stall_cnt", stall_cnt, exp_sc);

        // div without dependents, branch mid-flight must not abort it
        tick();
        clear_in();
        id_md_start = 1'b1; id_md_is_div = 1'b1;
        tick();
        clear_in();
        busy_n = 0; done_n = 0; stall_n = 0;
        for (int i = 0; i < 24; i++) begin
            ex_br_taken = (i == 5);
            #1;
            if (md_busy) busy_n++;
            if (md_done) done_n++;
            if (!pc_en) stall_n++;
            if (i == 15) chk("div_done_last_cycle", md_done, 1);
            tick();
        end
        clear_in();
        chk("div_busy_cycles", busy_n, 16);
        chk("div_done_pulses", done_n, 1);
        chk("div_stalls", stall_n, 0);
        chk("div_stall_cnt", stall_cnt, exp_sc);

        // reset in BUSY cycle 3 abandons the divide
        id_md_start = 1'b1; id_md_is_div = 1'b1;
        tick();
        clear_in();
        chk("rstbusy_c1", md_busy, 1);
        tick();
        tick();
        chk("rstbusy_c3", md_busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("rstbusy_busy", md_busy, 0);
        chk("rstbusy_stall_cnt", stall_cnt, 0);
        chk("rstbusy_pc_en", pc_en, 1);
        busy_n = 0; done_n = 0;
        for (int i = 0; i < 20; i++) begin
            if (md_busy) busy_n++;
            if (md_done) done_n++;
            tick();
        end
        chk("rstbusy_no_busy", busy_n, 0);
        chk("rstbusy_no_done", done_n, 0);

        // saturation: 21 held load-use stall cycles
        ex_memread = 1'b1; ex_rd = 5'd4; id_rs = 5'd4; id_uses_rs = 1'b1;
        for (int i = 0; i < 21; i++) begin
            tick();
            if (i == 14) chk("sat4_at15", stall_cnt4, 15);
            if (i == 15) chk("sat4_no_wrap", stall_cnt4, 15);
        end
        clear_in();
        chk("sat4_final", stall_cnt4, 15);
        chk("sat16_final", stall_cnt, 21);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
